// File: rtl/fifo_axis_reader_pkg.sv
// Shared constants, entry layout and helpers for the FIFO read-side AXI4-Stream drain engine.
// The buffer entry type is width-generic, so it is a macro that each module expands with its own B.
`ifndef FIFO_AXIS_READER_PKG_SV
`define FIFO_AXIS_READER_PKG_SV

`define FIFO_RD_ENTRY_T(W) struct packed { logic last; logic [(W)-1:0] data; }

package fifo_rd_pkg;

    localparam int LVL_W = 2;

    localparam logic [LVL_W-1:0] LVL_EMPTY = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(2);

    // Packet counter width; never below 1 so PKT_LEN=1 still gets a real register.
    function automatic int pkt_w(input int pkt_len);
        int w;
        w = $clog2(pkt_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`endif

// File: rtl/fifo_axis_reader_skid_buf2.sv
// Two-entry output skid buffer. The head drives the stream. Entries carry data plus the packet-end tag.
module axis_skid_buf2
    import fifo_rd_pkg::*;
#(
    parameter int B = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [B-1:0]     i_data,
    input  logic             i_last,
    input  logic             i_pop,
    output logic [B-1:0]     o_data,
    output logic             o_last,
    output logic             o_valid,
    output logic [LVL_W-1:0] o_level
);

    typedef `FIFO_RD_ENTRY_T(B) entry_t;

    entry_t           r_head;
    entry_t           r_tail;
    logic [LVL_W-1:0] r_level;
    entry_t           w_in;

    assign w_in = {i_last, i_data};

    // The upstream credit rule guarantees there is never a push into a full buffer without a pop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_level <= LVL_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_level)
                LVL_EMPTY: begin
                    if (i_push) begin
                        r_head  <= w_in;
                        r_level <= LVL_ONE;
                    end
                end
                LVL_ONE: begin
                    case ({i_push, i_pop})
                        2'b11: r_head <= w_in;
                        2'b10: begin
                            r_tail  <= w_in;
                            r_level <= LVL_FULL;
                        end
                        2'b01: r_level <= LVL_EMPTY;
                        default: ;
                    endcase
                end
                default: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail  <= w_in;
                        else        r_level <= LVL_ONE;
                    end
                end
            endcase
        end
    end

    assign o_data  = r_head.data;
    assign o_last  = r_head.last;
    assign o_valid = (r_level != LVL_EMPTY);
    assign o_level = r_level;

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a 1-cycle-latency BRAM FIFO into an AXI4-Stream master at 1 word/clk with full backpressure.
// Optional packet framing on m_axis_tlast is enabled by defining FIFO_RD_TLAST_EN.
module fifo_axis_reader
    import fifo_rd_pkg::*;
#(
    parameter int B       = 16,
    parameter int PKT_LEN = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty,
    input  logic [B-1:0]     fifo_dout,
    output logic             fifo_rd_en,
    output logic [B-1:0]     m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [LVL_W-1:0] buf_level
);

    logic             r_inflight;
    logic             w_pop;
    logic             w_last;
    logic             w_head_last;
    logic [LVL_W:0]   w_cnt;

    assign w_pop = m_axis_tvalid & m_axis_tready;

    // Credits cover words already buffered plus the one whose read data lands next edge.
    assign w_cnt      = {1'b0, buf_level} + {{LVL_W{1'b0}}, r_inflight};
    assign fifo_rd_en = rstn & ~fifo_empty & ((w_cnt < (LVL_W+1)'(2)) | w_pop);

    always_ff @(posedge clk) begin
        if (!rstn) r_inflight <= 1'b0;
        else       r_inflight <= fifo_rd_en;
    end

`ifdef FIFO_RD_TLAST_EN
    localparam int   PW       = pkt_w(PKT_LEN);
    localparam logic TLAST_ON = 1'b1;

    logic [PW-1:0] r_pkt_cnt;

    // Tag at buffer entry so the flag rides with its word through any stall.
    assign w_last = (r_pkt_cnt == PW'(PKT_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rstn)           r_pkt_cnt <= '0;
        else if (r_inflight) r_pkt_cnt <= w_last ? '0 : r_pkt_cnt + PW'(1);
    end
`else
    localparam logic TLAST_ON = 1'b0;

    assign w_last = 1'b0;
`endif

    axis_skid_buf2 #(
        .B (B)
    ) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_inflight),
        .i_data  (fifo_dout),
        .i_last  (w_last),
        .i_pop   (w_pop),
        .o_data  (m_axis_tdata),
        .o_last  (w_head_last),
        .o_valid (m_axis_tvalid),
        .o_level (buf_level)
    );

    assign m_axis_tlast = TLAST_ON & w_head_last;

endmodule
